serial_frame_ctrl: RTL and testbench
====================================

// Module: serial_frame_ctrl
// PURPOSE
//   Sequences one serial shift/latch channel (e.g. 74HC595-style display driver) clocked by clk_25k.
//   Shares the channel between two requesters via a round-robin arbiter.
//   Each granted word is emitted as one frame: a start pulse, FRAME_W serial bits MSB-first,
//   a str latch strobe, then IDLE_GAP idle cycles.
// PARAMETERS
//   FRAME_W   16  bits per frame; legal range 2..32
//   IDLE_GAP  2   idle cycles after str before next frame; legal range 0..15
// PORTS
//   clk_25k  in   1        system clock; all state changes on posedge
//   rst      in   1        reset, asynchronous, active-high
//   req0     in   1        requester 0 wants a frame; hold high with data0 stable until gnt0
//   data0    in   FRAME_W  requester 0 payload
//   req1     in   1        requester 1 wants a frame; hold high with data1 stable until gnt1
//   data1    in   FRAME_W  requester 1 payload
//   gnt0     out  1        1-cycle pulse: data0 captured
//   gnt1     out  1        1-cycle pulse: data1 captured
//   busy     out  1        high in every state except IDLE
//   start    out  1        1-cycle frame-start pulse
//   sdo      out  1        serial data, valid only in SHIFT, 0 elsewhere
//   str      out  1        1-cycle latch strobe after the last bit
//   done     out  1        1-cycle pulse, coincident with str
//   done_id  out  1        requester served by current/last frame; holds until next grant
// BEHAVIOUR
//   Reset:
//     - rst=1 forces IDLE immediately, with no clock edge needed.
//     - All outputs 0; shift reg and bit counter 0; RR pointer favours req0.
//   FSM states: IDLE -> START -> SHIFT -> STROBE -> GAP -> IDLE; GAP is skipped when IDLE_GAP=0.
//   IDLE:
//     - On an edge with req0|req1 sampled high, capture the winner's data into the shift reg and go to START.
//     - Winner: sole requester, else the one not served last (RR pointer).
//     - Pointer updates on every grant.
//   START (1 cycle): start=1, gnt<winner>=1, busy=1, sdo=0.
//   SHIFT (exactly FRAME_W cycles):
//     - Cycle k (0-based) drives sdo = data[FRAME_W-1-k].
//     - Bit counter is $clog2(FRAME_W) wide, counts 0..FRAME_W-1 and must not wrap early.
//   STROBE (1 cycle): str=1, done=1, sdo=0.
//   GAP (IDLE_GAP cycles): busy=1, requests ignored.
//   Frame length: 2+FRAME_W+IDLE_GAP cycles from start to busy low; first start is 1 cycle after req sampled.
//   Request handling:
//     - Requests are sampled only in IDLE.
//     - A req still high after its grant is a new request for the next frame.
//     - Input data changes after grant have no effect on the frame in flight.
//   Reset mid-frame:
//     - Aborts immediately; str is never issued for a partial frame.
//     - Pending reqs are re-arbitrated after release and restart from the MSB.
//   All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   - serial_frame_pkg: FSM state encodings (IDLE/START/SHIFT/STROBE/GAP), default FRAME_W/IDLE_GAP,
//     and the bit-counter width function.
//   - Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], advance -> grant[1:0], ptr).
//   - Top-level holds the FSM, shift register, bit counter and gap counter.
// TESTING (FRAME_W=16, IDLE_GAP=2 unless noted)
//   1. Release rst, req0=1, data0=16'hA5C3
//      -> start=gnt0=1 next cycle;
//      -> sdo = 1010_0101_1100_0011 over 16 cycles;
//      -> then str=done=1, done_id=0; busy high exactly 20 cycles.
//   2. req0 and req1 high together from reset (data1=16'h00FF)
//      -> frames served 0,1,0,1...; gnt0 and gnt1 never in the same frame;
//      -> start pulses 20 cycles apart.
//   3. Change data0 to 16'hFFFF the cycle after gnt0
//      -> sdo still shows 16'hA5C3.
//   4. Assert rst asynchronously during SHIFT bit 7
//      -> busy/sdo/start/str = 0 before the next edge; no str;
//      -> after release with req1 held, a full fresh frame of data1 starts at MSB.
//   5. IDLE_GAP=0, FRAME_W=8, req0 held high, data0=8'h81
//      -> start every 10 cycles; sdo 1000_0001 each frame.
//   6. req1 alone after a frame served to 1
//      -> granted immediately; RR does not stall a single requester.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame controller: state encoding,
// default geometry and the bit-counter width helper.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam int DEF_FRAME_W  = 16;
  localparam int DEF_IDLE_GAP = 2;

  // Width of a counter that must reach frame_w-1 without wrapping.
  function automatic int cnt_w(input int frame_w);
    return (frame_w < 2) ? 1 : $clog2(frame_w);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. ptr=0 favours req[0], ptr=1 favours req[1];
// after each advance the pointer favours the requester that was not served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  // Sole requester wins outright; a tie is broken by the pointer.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // Pointer moves away from whoever was just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= 1'b0;
    else if (advance && (grant != 2'b00)) ptr <= grant[0];
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial shift/latch channel sequencer shared by two requesters.
// Frame: START, FRAME_W bits MSB-first on sdo, STROBE (str/done), IDLE_GAP idle.
// The final cycle of a frame doubles as the arbitration point, so a held
// request starts the next frame back-to-back (period 2+FRAME_W+IDLE_GAP).
// Every output is a flop loaded from the next-state logic.
module serial_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int IDLE_GAP = DEF_IDLE_GAP
) (
  input  logic               clk_25k,
  input  logic               rst,
  input  logic               req0,
  input  logic [FRAME_W-1:0] data0,
  input  logic               req1,
  input  logic [FRAME_W-1:0] data1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               start,
  output logic               sdo,
  output logic               str,
  output logic               done,
  output logic               done_id
);

  localparam int              CNT_W    = cnt_w(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [3:0]      GAP_LAST = 4'(IDLE_GAP - 1);

  state_t             state, state_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [3:0]         gap, gap_n;
  logic               done_id_n;
  logic               take;
  logic               frame_end;
  logic [1:0]         grant;
  logic               arb_ptr;

  rr_arb2 u_arb (
    .clk     (clk_25k),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (take),
    .grant   (grant),
    .ptr     (arb_ptr)
  );

  // Next-state, datapath and arbitration decisions.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    gap_n     = gap;
    done_id_n = done_id;
    take      = 1'b0;
    frame_end = ((state == ST_STROBE) && (IDLE_GAP == 0)) ||
                ((state == ST_GAP) && (gap == GAP_LAST));
    case (state)
      ST_START: begin
        state_n = ST_SHIFT;
        cnt_n   = '0;
      end
      ST_SHIFT: begin
        shreg_n = {shreg[FRAME_W-2:0], 1'b0};
        if (cnt == CNT_LAST) state_n = ST_STROBE;
        else cnt_n = cnt + 1'b1;
      end
      ST_STROBE: begin
        state_n = ST_GAP;
        gap_n   = 4'd0;
      end
      ST_GAP: begin
        if (gap != GAP_LAST) gap_n = gap + 4'd1;
      end
      default: ;
    endcase
    if ((state == ST_IDLE) || frame_end) begin
      state_n = ST_IDLE;
      if (grant != 2'b00) begin
        take      = 1'b1;
        state_n   = ST_START;
        shreg_n   = grant[1] ? data1 : data0;
        done_id_n = grant[1];
      end
    end
  end

  // State, datapath and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk_25k or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      gap     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      start   <= 1'b0;
      sdo     <= 1'b0;
      str     <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      gap     <= gap_n;
      gnt0    <= take & grant[0];
      gnt1    <= take & grant[1];
      busy    <= (state_n != ST_IDLE);
      start   <= (state_n == ST_START);
      sdo     <= (state_n == ST_SHIFT) & shreg_n[FRAME_W-1];
      str     <= (state_n == ST_STROBE);
      done    <= (state_n == ST_STROBE);
      done_id <= done_id_n;
    end
  end

  // A grant pulse must coincide with the pointer favouring the other side.
  a_gnt0_ptr: assert property (@(posedge clk_25k) disable iff (rst) gnt0 |-> arb_ptr);
  a_gnt1_ptr: assert property (@(posedge clk_25k) disable iff (rst) gnt1 |-> !arb_ptr);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: one 16-bit/gap-2 instance and one
// 8-bit/gap-0 instance, expected values written out by hand.
module tb_serial_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic clk_25k = 1'b0;
  logic rst     = 1'b0;
  always #5 clk_25k = ~clk_25k;

  // ---------------- 16-bit instance ----------------
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, busy, start, sdo, str, done, done_id;

  serial_frame_ctrl #(.FRAME_W(16), .IDLE_GAP(2)) dut (
    .clk_25k (clk_25k), .rst (rst),
    .req0 (req0), .data0 (data0), .req1 (req1), .data1 (data1),
    .gnt0 (gnt0), .gnt1 (gnt1), .busy (busy), .start (start),
    .sdo (sdo), .str (str), .done (done), .done_id (done_id)
  );

  // ---------------- 8-bit, no-gap instance ----------------
  logic       r5_req0 = 1'b0, r5_req1 = 1'b0;
  logic [7:0] r5_data0 = '0, r5_data1 = '0;
  logic       r5_gnt0, r5_gnt1, r5_busy, r5_start, r5_sdo, r5_str, r5_done, r5_done_id;

  serial_frame_ctrl #(.FRAME_W(8), .IDLE_GAP(0)) dut5 (
    .clk_25k (clk_25k), .rst (rst),
    .req0 (r5_req0), .data0 (r5_data0), .req1 (r5_req1), .data1 (r5_data1),
    .gnt0 (r5_gnt0), .gnt1 (r5_gnt1), .busy (r5_busy), .start (r5_start),
    .sdo (r5_sdo), .str (r5_str), .done (r5_done), .done_id (r5_done_id)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // At a negedge inside START: check grant pulse and frame-start outputs.
  task automatic check_start(input string tag, input logic id);
    check({tag, " start"},   32'(start),   32'd1);
    check({tag, " gnt0"},    32'(gnt0),    32'(!id));
    check({tag, " gnt1"},    32'(gnt1),    32'(id));
    check({tag, " busy"},    32'(busy),    32'd1);
    check({tag, " sdo0"},    32'(sdo),     32'd0);
    check({tag, " str0"},    32'(str),     32'd0);
    check({tag, " done_id"}, 32'(done_id), 32'(id));
  endtask

  // Entered at the negedge of SHIFT bit 0; leaves at the negedge after the gap.
  task automatic check_body(input string tag, input logic [15:0] d, input logic id);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s sdo bit%0d", tag, k), 32'(sdo), 32'(d[15-k]));
      check($sformatf("%s start low %0d", tag, k), 32'(start | str | gnt0 | gnt1), 32'd0);
      @(negedge clk_25k);
    end
    check({tag, " str"},        32'(str),     32'd1);
    check({tag, " done"},       32'(done),    32'd1);
    check({tag, " done_id"},    32'(done_id), 32'(id));
    check({tag, " strobe sdo"}, 32'(sdo),     32'd0);
    @(negedge clk_25k);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s gap busy %0d", tag, g), 32'(busy), 32'd1);
      check($sformatf("%s gap quiet %0d", tag, g), 32'(start | str | sdo), 32'd0);
      @(negedge clk_25k);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    @(negedge clk_25k);
    check("rst busy",    32'(busy),    32'd0);
    check("rst start",   32'(start),   32'd0);
    check("rst sdo",     32'(sdo),     32'd0);
    check("rst str",     32'(str | done), 32'd0);
    check("rst gnt",     32'({gnt1, gnt0}), 32'd0);
    check("rst done_id", 32'(done_id), 32'd0);
    check("rst r5 busy", 32'(r5_busy), 32'd0);

    // 1 + 3: single frame, data changed after grant
    rst = 1'b0; req0 = 1'b1; data0 = 16'hA5C3;
    @(negedge clk_25k);
    check_start("t1", 1'b0);
    req0 = 1'b0; data0 = 16'hFFFF;
    @(negedge clk_25k);
    check_body("t1", 16'hA5C3, 1'b0);
    check("t1 busy low after 20", 32'(busy), 32'd0);

    // 2: both requesting from reset, alternate service, 20-cycle spacing
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 16'hA5C3; data1 = 16'h00FF;
    @(negedge clk_25k);
    rst = 1'b0;
    @(negedge clk_25k);
    for (int f = 0; f < 4; f++) begin
      check_start($sformatf("t2 f%0d", f), 1'(f % 2));
      if (f == 3) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk_25k);
      check_body($sformatf("t2 f%0d", f), (f % 2) ? 16'h00FF : 16'hA5C3, 1'(f % 2));
    end
    check("t2 busy low", 32'(busy), 32'd0);

    // 6: lone req1 right after serving requester 1
    req1 = 1'b1;
    @(negedge clk_25k);
    check_start("t6", 1'b1);
    req1 = 1'b0;
    @(negedge clk_25k);
    check_body("t6", 16'h00FF, 1'b1);
    check("t6 busy low", 32'(busy), 32'd0);

    // 4: asynchronous reset during SHIFT bit 7, then fresh frame
    data1 = 16'hFF00; req1 = 1'b1;
    @(negedge clk_25k);
    check_start("t4", 1'b1);
    @(negedge clk_25k);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4 pre sdo bit%0d", k), 32'(sdo), 32'(k >= 0 && k < 8 ? 1 : 0));
      if (k < 7) @(negedge clk_25k);
    end
    rst = 1'b1;
    #1;
    check("t4 async busy",  32'(busy),  32'd0);
    check("t4 async sdo",   32'(sdo),   32'd0);
    check("t4 async start", 32'(start), 32'd0);
    check("t4 async str",   32'(str),   32'd0);
    @(negedge clk_25k);
    check("t4 held str",    32'(str | done), 32'd0);
    rst = 1'b0;
    @(negedge clk_25k);
    check_start("t4 re", 1'b1);
    req1 = 1'b0;
    @(negedge clk_25k);
    check_body("t4 re", 16'hFF00, 1'b1);
    check("t4 busy low", 32'(busy), 32'd0);

    // 5: 8-bit, no gap, req0 held -> start every 10 cycles
    r5_req0 = 1'b1; r5_data0 = 8'h81;
    @(negedge clk_25k);
    for (int f = 0; f < 3; f++) begin
      check($sformatf("t5 f%0d start", f), 32'(r5_start), 32'd1);
      check($sformatf("t5 f%0d gnt0", f),  32'(r5_gnt0),  32'd1);
      if (f == 2) r5_req0 = 1'b0;
      @(negedge clk_25k);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("t5 f%0d sdo bit%0d", f, k), 32'(r5_sdo), 32'((k == 0 || k == 7) ? 1 : 0));
        check($sformatf("t5 f%0d no start %0d", f, k), 32'(r5_start), 32'd0);
        @(negedge clk_25k);
      end
      check($sformatf("t5 f%0d str", f), 32'(r5_str & r5_done), 32'd1);
      @(negedge clk_25k);
    end
    check("t5 busy low", 32'(r5_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
